// File: rtl/serial_adder_if.sv
// Purpose : operand/result handshake bundle for serial_adder.
// Signals : in_valid/in_ready/a/b/cin  - operand handshake (producer -> adder)
//           out_valid/out_ready/sum/cout - result handshake (adder -> consumer)
//           busy                         - adder is in RUN or DONE
// Modports: master = producer/consumer side, slave = the adder.
interface serial_adder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
endinterface

// File: rtl/serial_adder.sv
// Purpose : bit-serial ripple adder, {cout, sum} = a + b + cin, one bit per
//           clock through a single full-add slice (two half-adds + carry reg).
// Ports   : clk  - rising-edge clock
//           rst  - synchronous active-high reset
//           bus  - serial_adder_if.slave (operand and result handshakes, busy)
// Timing  : result valid WIDTH cycles after acceptance; all outputs registered.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    serial_adder_if.slave  bus
);
    localparam int unsigned     CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;
    logic             w_in_ready_nxt;
    logic             w_out_valid_nxt;
    logic             w_busy_nxt;

    // A shift register doubles as the sum accumulator: each sum bit enters
    // at the MSB as the consumed operand bit leaves at the LSB.
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_accept;
    logic             w_last;
    logic             w_ha0_s;
    logic             w_ha0_c;
    logic             w_ha1_s;
    logic             w_ha1_c;
    logic             w_c_next;
    logic [WIDTH:0]   w_acc_ext;
    logic [WIDTH-1:0] w_acc_nxt;

    assign w_accept = bus.in_valid & r_in_ready & (r_state == S_IDLE);
    assign w_last   = (r_cnt == LAST_BIT);

    // Full-add slice from two half-add stages.
    assign w_ha0_s   = r_a_sh[0] ^ r_b_sh[0];
    assign w_ha0_c   = r_a_sh[0] & r_b_sh[0];
    assign w_ha1_s   = w_ha0_s ^ r_carry;
    assign w_ha1_c   = w_ha0_s & r_carry;
    assign w_c_next  = w_ha0_c | w_ha1_c;
    assign w_acc_ext = {w_ha1_s, r_a_sh};
    assign w_acc_nxt = w_acc_ext[WIDTH:1];

    // State register plus registered handshake/status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)      w_state_nxt = S_RUN;
            S_RUN:   if (w_last)        w_state_nxt = S_DONE;
            S_DONE:  if (bus.out_ready) w_state_nxt = S_IDLE;
            default:                    w_state_nxt = S_IDLE;
        endcase
    end

    // Flags decoded from the next state so they line up with the state register.
    always_comb begin
        w_in_ready_nxt  = 1'b0;
        w_out_valid_nxt = 1'b0;
        w_busy_nxt      = 1'b0;
        case (w_state_nxt)
            S_IDLE:  w_in_ready_nxt  = 1'b1;
            S_RUN:   w_busy_nxt      = 1'b1;
            S_DONE: begin
                w_out_valid_nxt = 1'b1;
                w_busy_nxt      = 1'b1;
            end
            default: w_in_ready_nxt  = 1'b0;
        endcase
    end

    // Datapath: capture on accept, one bit per RUN cycle, latch result on last bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            r_a_sh  <= bus.a;
            r_b_sh  <= bus.b;
            r_carry <= bus.cin;
            r_cnt   <= '0;
        end else if (r_state == S_RUN) begin
            r_a_sh  <= w_acc_nxt;
            r_b_sh  <= r_b_sh >> 1;
            r_carry <= w_c_next;
            r_cnt   <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_sum  <= w_acc_nxt;
                r_cout <= w_c_next;
            end
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
endmodule
